// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with the winc/rinc/wfull/rempty
// handshake, occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush (clr).
// Build option: define FIFO_FWFT_EN for first-word-fall-through read data;
// leave it undefined for the standard registered read port (latency 1).
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              winc,
  output logic              wfull,
  output logic              almost_full,
  input  logic              rinc,
  output logic [DATA_W-1:0] rdata,
  output logic              rempty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0] ZERO_C   = '0;
  localparam logic [ADDR_W:0] ONE_C    = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W:0]   wptr_r;
  logic [ADDR_W:0]   rptr_r;
  logic [ADDR_W:0]   count_s;
  logic              wr_accept_s;
  logic              rd_accept_s;
  logic              overflow_r;
  logic              underflow_r;

  // Occupancy and status flags derived from the registered pointers; a flush
  // cycle suppresses both requests so no pointer or memory moves.
  always_comb begin
    count_s     = wptr_r - rptr_r;
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    if (clr) begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
    end else begin
      wr_accept_s = winc && (count_s != DEPTH_C);
      rd_accept_s = rinc && (count_s != ZERO_C);
    end
  end

  assign count        = count_s;
  assign wfull        = (count_s == DEPTH_C);
  assign rempty       = (count_s == ZERO_C);
  assign almost_full  = (count_s >= AFULL_C);
  assign almost_empty = (count_s <= AEMPTY_C);
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // Write/read pointers: wrap naturally modulo 2**(ADDR_W+1), flush returns both to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= ZERO_C;
      rptr_r <= ZERO_C;
    end else if (clr) begin
      wptr_r <= ZERO_C;
      rptr_r <= ZERO_C;
    end else begin
      if (wr_accept_s) begin
        wptr_r <= wptr_r + ONE_C;
      end
      if (rd_accept_s) begin
        rptr_r <= rptr_r + ONE_C;
      end
    end
  end

  // Sticky error flags: any rejected write while full / read while empty, held until flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clr) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (winc && (count_s == DEPTH_C));
      underflow_r <= underflow_r | (rinc && (count_s == ZERO_C));
    end
  end

  // Storage array: written only on an accepted write, contents survive flush.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wptr_r[ADDR_W-1:0]] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown continuously; a read simply advances past it.
  assign rdata = mem_r[rptr_r[ADDR_W-1:0]];
`else
  logic [DATA_W-1:0] rdata_r;

  // Registered read port: loads the head word on the edge a read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (rd_accept_s) begin
      rdata_r <= mem_r[rptr_r[ADDR_W-1:0]];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;
`endif

endmodule
